// File: rtl/gram_phy_init_pkg.sv
// rtl/gram_phy_init_pkg.sv - shared state encoding, timing defaults and counter sizing for the ECP5 PHY init sequencer.
package gram_phy_init_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FREEZE    = 4'd1,
    STOP      = 4'd2,
    RESET     = 4'd3,
    WAIT_LOCK = 4'd4,
    UNSTOP    = 4'd5,
    UNFREEZE  = 4'd6,
    UPDATE    = 4'd7,
    PAUSE_REL = 4'd8,
    DONE      = 4'd9,
    ERROR     = 4'd10
  } phy_init_state_e;

  localparam int DEF_CYC_STEP     = 8;
  localparam int DEF_UPDATE_CYC   = 4;
  localparam int DEF_LOCK_STABLE  = 4;
  localparam int DEF_LOCK_TIMEOUT = 1024;

  // One width fits every counter so the shared timer can hold any load value.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/phy_init_timer.sv
// rtl/phy_init_timer.sv - loadable down-counter that paces every timed step of the init sequence.
module phy_init_timer #(
  parameter int W = 4
) (
  input  logic         clkin,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (value_q != '0) begin
      value_d = value_q - W'(1);
    end
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/ecp5_phy_init_seq.sv
// rtl/ecp5_phy_init_seq.sv - ECP5 DDR clock start-up handshake and DQS update server.
// Optional WAIT_LOCK timeout to an ERROR state: PHY_INIT_LOCK_TIMEOUT_EN.
module ecp5_phy_init_seq
  import gram_phy_init_pkg::*;
#(
  parameter int CYC_STEP     = DEF_CYC_STEP,
  parameter int UPDATE_CYC   = DEF_UPDATE_CYC,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic init_req,
  input  logic update_req,
  input  logic dll_lock,
  output logic freeze,
  output logic stop,
  output logic ddr_rst,
  output logic pause,
  output logic uddcntln,
  output logic ready,
  output logic error
);

  localparam int CW = cnt_width(CYC_STEP, UPDATE_CYC, LOCK_STABLE, LOCK_TIMEOUT);
  localparam logic [CW-1:0] STEP_LD   = CW'(CYC_STEP - 1);
  localparam logic [CW-1:0] UPD_LD    = CW'(UPDATE_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE - 1);
`ifdef PHY_INIT_LOCK_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LD    = CW'(LOCK_TIMEOUT - 1);
`endif

  phy_init_state_e state_q, state_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            init_req_q, init_req_d;
  logic            init_edge;
  logic            tmr_load;
  logic [CW-1:0]   tmr_ld_val;
  logic [CW-1:0]   tmr_value;
  logic            tmr_zero;

  phy_init_timer #(.W(CW)) u_timer (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_ld_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  assign init_edge = init_req & ~init_req_q;

  always_comb begin
    state_d    = state_q;
    init_req_d = init_req;
    lock_cnt_d = '0;
    tmr_load   = 1'b0;
    tmr_ld_val = STEP_LD;
    case (state_q)
      IDLE: begin
        if (init_edge) begin
          state_d  = FREEZE;
          tmr_load = 1'b1;
        end
      end
      FREEZE: begin
        if (tmr_zero) begin
          state_d  = STOP;
          tmr_load = 1'b1;
        end
      end
      STOP: begin
        if (tmr_zero) begin
          state_d  = RESET;
          tmr_load = 1'b1;
        end
      end
      RESET: begin
        if (tmr_zero) begin
          state_d = WAIT_LOCK;
`ifdef PHY_INIT_LOCK_TIMEOUT_EN
          tmr_load   = 1'b1;
          tmr_ld_val = TMO_LD;
`endif
        end
      end
      WAIT_LOCK: begin
        // Exit on the cycle whose sample completes the run of consecutive lock highs.
        if (dll_lock && (lock_cnt_q == LOCK_LAST)) begin
          state_d  = UNSTOP;
          tmr_load = 1'b1;
        end else begin
          lock_cnt_d = dll_lock ? (lock_cnt_q + CW'(1)) : '0;
`ifdef PHY_INIT_LOCK_TIMEOUT_EN
          if (tmr_zero) begin
            state_d = ERROR;
          end
`endif
        end
      end
      UNSTOP: begin
        if (tmr_zero) begin
          state_d  = UNFREEZE;
          tmr_load = 1'b1;
        end
      end
      UNFREEZE: begin
        if (tmr_zero) begin
          state_d    = UPDATE;
          tmr_load   = 1'b1;
          tmr_ld_val = UPD_LD;
        end
      end
      UPDATE: begin
        if (tmr_zero) begin
          state_d  = PAUSE_REL;
          tmr_load = 1'b1;
        end
      end
      PAUSE_REL: begin
        if (tmr_zero) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (init_edge) begin
          state_d  = FREEZE;
          tmr_load = 1'b1;
        end else if (update_req) begin
          state_d    = UPDATE;
          tmr_load   = 1'b1;
          tmr_ld_val = UPD_LD;
        end
      end
`ifdef PHY_INIT_LOCK_TIMEOUT_EN
      ERROR: begin
        if (init_edge) begin
          state_d  = FREEZE;
          tmr_load = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      init_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      init_req_q <= init_req_d;
    end
  end

  always_comb begin
    freeze   = 1'b0;
    stop     = 1'b0;
    ddr_rst  = 1'b0;
    pause    = 1'b0;
    uddcntln = 1'b1;
    ready    = 1'b0;
    error    = 1'b0;
    case (state_q)
      FREEZE:    freeze = 1'b1;
      STOP: begin
        freeze = 1'b1;
        stop   = 1'b1;
      end
      RESET: begin
        freeze  = 1'b1;
        stop    = 1'b1;
        ddr_rst = 1'b1;
      end
      WAIT_LOCK: begin
        freeze = 1'b1;
        stop   = 1'b1;
      end
      UNSTOP:    freeze = 1'b1;
      UPDATE: begin
        pause    = 1'b1;
        uddcntln = 1'b0;
      end
      PAUSE_REL: pause = 1'b1;
      DONE:      ready = 1'b1;
`ifdef PHY_INIT_LOCK_TIMEOUT_EN
      ERROR:     error = 1'b1;
`endif
      default: begin
        freeze = 1'b0;
      end
    endcase
  end

  a_timer_zero_consistent: assert property (@(posedge clkin) tmr_zero == (tmr_value == '0));

endmodule

// File: tb/tb_ecp5_phy_init_seq.sv
// tb/tb_ecp5_phy_init_seq.sv - table-driven scoreboard bench for ecp5_phy_init_seq.
module tb_ecp5_phy_init_seq;

  logic clkin = 1'b0;
  always #5 clkin = ~clkin;

  logic rst_n, init_req, update_req, dll_lock;
  logic freeze, stop, ddr_rst, pause, uddcntln, ready, error;

  ecp5_phy_init_seq #(
    .CYC_STEP     (8),
    .UPDATE_CYC   (4),
    .LOCK_STABLE  (4),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .init_req   (init_req),
    .update_req (update_req),
    .dll_lock   (dll_lock),
    .freeze     (freeze),
    .stop       (stop),
    .ddr_rst    (ddr_rst),
    .pause      (pause),
    .uddcntln   (uddcntln),
    .ready      (ready),
    .error      (error)
  );

  // Output vector order: {freeze, stop, ddr_rst, pause, uddcntln, ready, error}
  localparam logic [6:0] O_IDLE = 7'b0000100;
  localparam logic [6:0] O_FRZ  = 7'b1000100;
  localparam logic [6:0] O_STP  = 7'b1100100;
  localparam logic [6:0] O_RST  = 7'b1110100;
  localparam logic [6:0] O_WL   = 7'b1100100;
  localparam logic [6:0] O_UNS  = 7'b1000100;
  localparam logic [6:0] O_UNF  = 7'b0000100;
  localparam logic [6:0] O_UPD  = 7'b0001000;
  localparam logic [6:0] O_PREL = 7'b0001100;
  localparam logic [6:0] O_DONE = 7'b0000110;
  localparam logic [6:0] O_ERR  = 7'b0000101;

  typedef struct {
    logic       rst;
    logic       init;
    logic       upd;
    logic       lock;
    int         n;
    logic [6:0] exp;
  } row_t;

  row_t       tbl[$];
  logic [6:0] sb_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         step     = 0;

  function automatic row_t mk(input logic rst, input logic init, input logic upd,
                              input logic lock, input int n, input logic [6:0] exp);
    row_t r;
    r.rst = rst; r.init = init; r.upd = upd; r.lock = lock; r.n = n; r.exp = exp;
    return r;
  endfunction

  task automatic check(input string tag);
    logic [6:0] act;
    logic [6:0] exp;
    act = {freeze, stop, ddr_rst, pause, uddcntln, ready, error};
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s step=%0d scoreboard empty got=%b", tag, step, act);
    end else begin
      exp = sb_q.pop_front();
      if (act === exp) n_pass++;
      else $display("FAIL %s step=%0d got=%b exp=%b", tag, step, act, exp);
    end
  endtask

  task automatic apply_row(input row_t r, input string tag);
    for (int i = 0; i < r.n; i++) begin
      @(negedge clkin);
      rst_n      = r.rst;
      init_req   = r.init;
      update_req = r.upd;
      dll_lock   = r.lock;
      sb_q.push_back(r.exp);
      #1;
      check(tag);
      step++;
    end
  endtask

  initial begin
    rst_n = 1'b0; init_req = 1'b0; update_req = 1'b0; dll_lock = 1'b0;
    repeat (2) @(posedge clkin);

    // Reset, then full bring-up with dll_lock held high (cycle 0 = first released edge).
    tbl.push_back(mk(0, 0, 0, 1, 2, O_IDLE));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_IDLE));
    tbl.push_back(mk(1, 1, 0, 1, 8, O_FRZ));
    tbl.push_back(mk(1, 1, 0, 1, 8, O_STP));
    tbl.push_back(mk(1, 1, 0, 1, 8, O_RST));
    tbl.push_back(mk(1, 1, 0, 1, 4, O_WL));
    tbl.push_back(mk(1, 1, 0, 1, 8, O_UNS));
    tbl.push_back(mk(1, 1, 0, 1, 8, O_UNF));
    tbl.push_back(mk(1, 1, 0, 1, 4, O_UPD));
    tbl.push_back(mk(1, 1, 0, 1, 8, O_PREL));
    tbl.push_back(mk(1, 1, 0, 1, 4, O_DONE));
    // Periodic update from DONE.
    tbl.push_back(mk(1, 1, 1, 1, 1, O_DONE));
    tbl.push_back(mk(1, 1, 0, 1, 4, O_UPD));
    tbl.push_back(mk(1, 1, 0, 1, 8, O_PREL));
    tbl.push_back(mk(1, 1, 0, 1, 3, O_DONE));
    // Init edge together with update_req: restart wins.
    tbl.push_back(mk(1, 0, 0, 1, 2, O_DONE));
    tbl.push_back(mk(1, 1, 1, 1, 1, O_DONE));
    tbl.push_back(mk(1, 1, 0, 1, 8, O_FRZ));
    // init_req toggled during STOP is ignored.
    tbl.push_back(mk(1, 0, 0, 1, 3, O_STP));
    tbl.push_back(mk(1, 1, 0, 1, 2, O_STP));
    tbl.push_back(mk(1, 0, 0, 1, 1, O_STP));
    tbl.push_back(mk(1, 1, 0, 1, 2, O_STP));
    tbl.push_back(mk(1, 1, 0, 0, 8, O_RST));
    // Lock pattern 1,1,1,0,1,1,1,1 in WAIT_LOCK.
    tbl.push_back(mk(1, 1, 0, 1, 3, O_WL));
    tbl.push_back(mk(1, 1, 0, 0, 1, O_WL));
    tbl.push_back(mk(1, 1, 0, 1, 4, O_WL));
    // Lock loss after WAIT_LOCK is ignored; update_req outside DONE too.
    tbl.push_back(mk(1, 1, 0, 0, 8, O_UNS));
    tbl.push_back(mk(1, 1, 1, 0, 8, O_UNF));
    tbl.push_back(mk(1, 1, 0, 0, 4, O_UPD));
    tbl.push_back(mk(1, 1, 0, 0, 8, O_PREL));
    tbl.push_back(mk(1, 1, 0, 0, 2, O_DONE));
    // New edge in DONE, then reset during RESET and restart.
    tbl.push_back(mk(1, 0, 0, 1, 1, O_DONE));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_DONE));
    tbl.push_back(mk(1, 1, 0, 1, 8, O_FRZ));
    tbl.push_back(mk(1, 1, 0, 1, 8, O_STP));
    tbl.push_back(mk(1, 1, 0, 1, 3, O_RST));
    tbl.push_back(mk(0, 1, 0, 1, 1, O_RST));
    tbl.push_back(mk(0, 1, 0, 1, 1, O_IDLE));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_IDLE));
    tbl.push_back(mk(1, 1, 0, 1, 8, O_FRZ));
    tbl.push_back(mk(1, 1, 0, 1, 2, O_STP));

    for (int k = 0; k < tbl.size(); k++) begin
      apply_row(tbl[k], $sformatf("row%0d", k));
    end

    // Hand-written: hold dll_lock low through WAIT_LOCK.
    apply_row(mk(1, 1, 0, 0, 6, O_STP), "lock_lo_stp");
    apply_row(mk(1, 1, 0, 0, 8, O_RST), "lock_lo_rst");
`ifdef PHY_INIT_LOCK_TIMEOUT_EN
    apply_row(mk(1, 1, 0, 0, 16, O_WL), "tmo_wait");
    apply_row(mk(1, 1, 1, 1, 3, O_ERR), "tmo_err");
    apply_row(mk(1, 0, 0, 1, 1, O_ERR), "tmo_err_low");
    apply_row(mk(1, 1, 0, 1, 1, O_ERR), "tmo_err_edge");
    apply_row(mk(1, 1, 0, 1, 2, O_FRZ), "tmo_restart");
`else
    apply_row(mk(1, 1, 0, 0, 40, O_WL), "wait_forever");
    apply_row(mk(1, 1, 0, 1, 4, O_WL), "late_lock");
    apply_row(mk(1, 1, 0, 1, 1, O_UNS), "late_unstop");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
